// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: forwarding scoreboard for an N-wide issue stage.
// Tracks in-flight writers as {valid, rdst, avail} records that move in lockstep
// with the pipeline. Resolves each issuing operand to forward / regfile / stall.
module bypass_scoreboard #(
    parameter int ISSUE_W = 2,
    parameter int NSTAGE  = 4,
    parameter int DATA_W  = 32,
    parameter int RA_W    = 5,
    parameter int AV_W    = $clog2(NSTAGE)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             adv_i,
    input  logic [NSTAGE-1:0]                flush_i,
    input  logic [ISSUE_W-1:0]               issue_valid_i,
    input  logic [ISSUE_W*RA_W-1:0]          issue_rdst_i,
    input  logic [ISSUE_W*AV_W-1:0]          issue_avail_i,
    input  logic [ISSUE_W*RA_W-1:0]          issue_ra1_i,
    input  logic [ISSUE_W*RA_W-1:0]          issue_ra2_i,
    input  logic [NSTAGE*ISSUE_W*DATA_W-1:0] stage_data_i,
    output logic [ISSUE_W-1:0]               ra1_ready_o,
    output logic [ISSUE_W-1:0]               ra2_ready_o,
    output logic [ISSUE_W-1:0]               ra1_bypass_o,
    output logic [ISSUE_W-1:0]               ra2_bypass_o,
    output logic [ISSUE_W*DATA_W-1:0]        ra1_data_o,
    output logic [ISSUE_W*DATA_W-1:0]        ra2_data_o,
    output logic [31:0]                      stall_cnt_o
);

    // Writer records, indexed [stage][slot]
    logic              r_valid [NSTAGE][ISSUE_W];
    logic [RA_W-1:0]   r_rdst  [NSTAGE][ISSUE_W];
    logic [AV_W-1:0]   r_avail [NSTAGE][ISSUE_W];
    logic [31:0]       r_stallCnt;

    // Per-operand lookup results, indexed [operand][slot]
    logic [RA_W-1:0]   w_ra     [2][ISSUE_W];
    logic              w_ready  [2][ISSUE_W];
    logic              w_bypass [2][ISSUE_W];
    logic [DATA_W-1:0] w_data   [2][ISSUE_W];
    logic              w_anyStall;

    // Unpack both source operand fields into one array so lookup is a single loop
    always_comb begin
        for (int w = 0; w < ISSUE_W; w++) begin
            w_ra[0][w] = issue_ra1_i[w*RA_W +: RA_W];
            w_ra[1][w] = issue_ra2_i[w*RA_W +: RA_W];
        end
    end

    // Operand resolution: in-group RAW first, then youngest matching record wins
    always_comb begin
        logic              raw;
        logic              hit;
        logic              hitFwd;
        logic [DATA_W-1:0] hitData;
        for (int op = 0; op < 2; op++) begin
            for (int w = 0; w < ISSUE_W; w++) begin
                raw     = 1'b0;
                hit     = 1'b0;
                hitFwd  = 1'b0;
                hitData = '0;
                for (int v = 0; v < w; v++) begin
                    if (issue_valid_i[v] && (issue_rdst_i[v*RA_W +: RA_W] == w_ra[op][w])
                        && (w_ra[op][w] != '0)) begin
                        raw = 1'b1;
                    end
                end
                // Scan oldest-to-youngest and lowest-to-highest slot so the last
                // hit written is the youngest stage, highest slot
                for (int s = NSTAGE-1; s >= 0; s--) begin
                    for (int v = 0; v < ISSUE_W; v++) begin
                        if (r_valid[s][v] && (r_rdst[s][v] == w_ra[op][w])
                            && (w_ra[op][w] != '0)) begin
                            hit     = 1'b1;
                            hitFwd  = (r_avail[s][v] <= AV_W'(s));
                            hitData = stage_data_i[(s*ISSUE_W+v)*DATA_W +: DATA_W];
                        end
                    end
                end
                w_ready[op][w]  = 1'b1;
                w_bypass[op][w] = 1'b0;
                w_data[op][w]   = '0;
                if (raw) begin
                    w_ready[op][w] = 1'b0;
                end else if (hit) begin
                    if (hitFwd) begin
                        w_bypass[op][w] = 1'b1;
                        w_data[op][w]   = hitData;
                    end else begin
                        w_ready[op][w] = 1'b0;
                    end
                end
            end
        end
    end

    // Pack lookup results onto the output ports and detect a stalling slot
    always_comb begin
        ra1_ready_o  = '0;
        ra2_ready_o  = '0;
        ra1_bypass_o = '0;
        ra2_bypass_o = '0;
        ra1_data_o   = '0;
        ra2_data_o   = '0;
        w_anyStall   = 1'b0;
        for (int w = 0; w < ISSUE_W; w++) begin
            ra1_ready_o[w]                 = w_ready[0][w];
            ra2_ready_o[w]                 = w_ready[1][w];
            ra1_bypass_o[w]                = w_bypass[0][w];
            ra2_bypass_o[w]                = w_bypass[1][w];
            ra1_data_o[w*DATA_W +: DATA_W] = w_data[0][w];
            ra2_data_o[w*DATA_W +: DATA_W] = w_data[1][w];
            if (issue_valid_i[w] && !(w_ready[0][w] && w_ready[1][w])) begin
                w_anyStall = 1'b1;
            end
        end
    end

    // Record pipeline: flush applies before advance, so a flushed record never moves
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int w = 0; w < ISSUE_W; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_rdst[s][w]  <= '0;
                    r_avail[s][w] <= '0;
                end
            end
        end else if (adv_i) begin
            for (int s = NSTAGE-1; s >= 1; s--) begin
                for (int w = 0; w < ISSUE_W; w++) begin
                    r_valid[s][w] <= r_valid[s-1][w] && !flush_i[s-1];
                    r_rdst[s][w]  <= r_rdst[s-1][w];
                    r_avail[s][w] <= r_avail[s-1][w];
                end
            end
            for (int w = 0; w < ISSUE_W; w++) begin
                r_valid[0][w] <= issue_valid_i[w] && (issue_rdst_i[w*RA_W +: RA_W] != '0)
                                 && !flush_i[0];
                r_rdst[0][w]  <= issue_rdst_i[w*RA_W +: RA_W];
                r_avail[0][w] <= issue_avail_i[w*AV_W +: AV_W];
            end
        end else begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int w = 0; w < ISSUE_W; w++) begin
                    if (flush_i[s]) begin
                        r_valid[s][w] <= 1'b0;
                    end
                end
            end
        end
    end

    // Saturating count of held cycles in which an issuing slot could not get an operand
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stallCnt <= '0;
        end else if (!adv_i && w_anyStall && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stallCnt;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb_bypass_scoreboard: directed vectors with hand-computed expectations
// for the forwarding scoreboard at its default parameters (2 slots, 4 stages).
module tb_bypass_scoreboard;

    localparam int IW = 2;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int AW = 2;

    logic              clk;
    logic              resetn;
    logic              adv;
    logic [NS-1:0]     flush;
    logic [IW-1:0]     issueValid;
    logic [IW*RW-1:0]  issueRdst;
    logic [IW*AW-1:0]  issueAvail;
    logic [IW*RW-1:0]  issueRa1;
    logic [IW*RW-1:0]  issueRa2;
    logic [NS*IW*DW-1:0] stageData;
    logic [IW-1:0]     ra1Ready;
    logic [IW-1:0]     ra2Ready;
    logic [IW-1:0]     ra1Bypass;
    logic [IW-1:0]     ra2Bypass;
    logic [IW*DW-1:0]  ra1Data;
    logic [IW*DW-1:0]  ra2Data;
    logic [31:0]       stallCnt;

    int checks   = 0;
    int failures = 0;

    bypass_scoreboard dut (
        .clk           (clk),
        .resetn        (resetn),
        .adv_i         (adv),
        .flush_i       (flush),
        .issue_valid_i (issueValid),
        .issue_rdst_i  (issueRdst),
        .issue_avail_i (issueAvail),
        .issue_ra1_i   (issueRa1),
        .issue_ra2_i   (issueRa2),
        .stage_data_i  (stageData),
        .ra1_ready_o   (ra1Ready),
        .ra2_ready_o   (ra2Ready),
        .ra1_bypass_o  (ra1Bypass),
        .ra2_bypass_o  (ra2Bypass),
        .ra1_data_o    (ra1Data),
        .ra2_data_o    (ra2Data),
        .stall_cnt_o   (stallCnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one issue slot's fields
    task automatic applyStimulus(input int w, input int valid, input int rdst,
                                 input int avail, input int ra1, input int ra2);
        issueValid[w]          = (valid != 0);
        issueRdst[w*RW +: RW]  = RW'(rdst);
        issueAvail[w*AW +: AW] = AW'(avail);
        issueRa1[w*RW +: RW]   = RW'(ra1);
        issueRa2[w*RW +: RW]   = RW'(ra2);
    endtask

    task automatic setData(input int s, input int w, input logic [31:0] value);
        stageData[(s*IW+w)*DW +: DW] = value;
    endtask

    task automatic clearInputs();
        adv        = 1'b0;
        flush      = '0;
        issueValid = '0;
        issueRdst  = '0;
        issueAvail = '0;
        issueRa1   = '0;
        issueRa2   = '0;
        stageData  = '0;
    endtask

    // Move past the next rising edge so inputs change and outputs settle mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        clearInputs();
        repeat (2) tick();

        // Reset state: unknown-free lookup reads the register file
        applyStimulus(0, 0, 0, 0, 5, 0);
        #1;
        checkOutput("rst_ready",  32'(ra1Ready[0]),  32'd1);
        checkOutput("rst_bypass", 32'(ra1Bypass[0]), 32'd0);
        checkOutput("rst_data",   ra1Data[31:0],     32'd0);
        checkOutput("rst_stall",  stallCnt,          32'd0);
        resetn = 1'b1;

        // ALU writer r3 forwarded from stage 0 in the next cycle
        tick();
        clearInputs();
        adv = 1'b1;
        applyStimulus(0, 1, 3, 0, 0, 0);
        tick();
        clearInputs();
        applyStimulus(1, 0, 0, 0, 0, 3);
        setData(0, 0, 32'h0000_1234);
        #1;
        checkOutput("alu_ready",  32'(ra2Ready[1]),  32'd1);
        checkOutput("alu_bypass", 32'(ra2Bypass[1]), 32'd1);
        checkOutput("alu_data",   ra2Data[63:32],    32'h0000_1234);

        // Load r4 with avail=2: stalls at stages 0 and 1, forwards at stage 2
        clearInputs();
        adv = 1'b1;
        applyStimulus(0, 1, 4, 2, 0, 0);
        tick();
        clearInputs();
        applyStimulus(0, 1, 0, 0, 4, 0);
        #1;
        checkOutput("ld_s0_ready", 32'(ra1Ready[0]),  32'd0);
        checkOutput("ld_s0_byp",   32'(ra1Bypass[0]), 32'd0);
        checkOutput("ld_s0_stall", stallCnt,          32'd0);
        tick();
        checkOutput("ld_stall1", stallCnt, 32'd1);
        adv = 1'b1;
        tick();
        adv = 1'b0;
        #1;
        checkOutput("ld_s1_ready", 32'(ra1Ready[0]), 32'd0);
        tick();
        checkOutput("ld_stall2", stallCnt, 32'd2);
        adv = 1'b1;
        tick();
        adv = 1'b0;
        setData(2, 0, 32'hCAFE_0004);
        #1;
        checkOutput("ld_s2_ready", 32'(ra1Ready[0]),  32'd1);
        checkOutput("ld_s2_byp",   32'(ra1Bypass[0]), 32'd1);
        checkOutput("ld_s2_data",  ra1Data[31:0],     32'hCAFE_0004);
        tick();
        checkOutput("ld_stall_hold", stallCnt, 32'd2);

        // r7 written at stage1 slot0 and stage0 slot1: youngest wins
        clearInputs();
        adv = 1'b1;
        applyStimulus(0, 1, 7, 0, 0, 0);
        tick();
        clearInputs();
        adv = 1'b1;
        applyStimulus(1, 1, 7, 0, 0, 0);
        tick();
        clearInputs();
        applyStimulus(0, 0, 0, 0, 7, 0);
        setData(0, 1, 32'h7000_0001);
        setData(1, 0, 32'h7000_0010);
        #1;
        checkOutput("prio_bypass", 32'(ra1Bypass[0]), 32'd1);
        checkOutput("prio_data",   ra1Data[31:0],     32'h7000_0001);

        // In-group RAW on r8: slot 1 stalls, slot 0 reads the register file
        clearInputs();
        applyStimulus(0, 1, 8, 0, 0, 8);
        applyStimulus(1, 1, 0, 0, 8, 0);
        #1;
        checkOutput("raw_s1_ready",  32'(ra1Ready[1]),  32'd0);
        checkOutput("raw_s1_bypass", 32'(ra1Bypass[1]), 32'd0);
        checkOutput("raw_s0_ready",  32'(ra2Ready[0]),  32'd1);
        checkOutput("raw_s0_bypass", 32'(ra2Bypass[0]), 32'd0);
        tick();
        checkOutput("raw_stall", stallCnt, 32'd3);

        // Writer to r0 never creates a record
        clearInputs();
        adv = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 0);
        tick();
        clearInputs();
        setData(0, 0, 32'hDEAD_0000);
        #1;
        checkOutput("r0_ready",  32'(ra1Ready[0]),  32'd1);
        checkOutput("r0_bypass", 32'(ra1Bypass[0]), 32'd0);
        checkOutput("r0_data",   ra1Data[31:0],     32'd0);

        // Held cycle ignores an issuing group
        clearInputs();
        applyStimulus(0, 1, 10, 0, 0, 0);
        tick();
        clearInputs();
        applyStimulus(0, 0, 0, 0, 10, 0);
        setData(0, 0, 32'h0000_00AA);
        #1;
        checkOutput("hold_bypass", 32'(ra1Bypass[0]), 32'd0);
        checkOutput("hold_ready",  32'(ra1Ready[0]),  32'd1);

        // Flush of stage 1 removes a pending avail=3 writer of r9
        clearInputs();
        adv = 1'b1;
        applyStimulus(0, 1, 9, 3, 0, 0);
        tick();
        clearInputs();
        adv = 1'b1;
        tick();
        clearInputs();
        adv   = 1'b1;
        flush = 4'b0010;
        applyStimulus(0, 0, 0, 0, 9, 0);
        #1;
        checkOutput("flush_pre_ready", 32'(ra1Ready[0]), 32'd0);
        tick();
        clearInputs();
        applyStimulus(0, 0, 0, 0, 9, 0);
        setData(2, 0, 32'h0000_0099);
        #1;
        checkOutput("flush_ready",  32'(ra1Ready[0]),  32'd1);
        checkOutput("flush_bypass", 32'(ra1Bypass[0]), 32'd0);
        checkOutput("flush_data",   ra1Data[31:0],     32'd0);

        // Fill all 8 records (r11..r18, avail=3), then stall up to 12
        for (int g = 0; g < 4; g++) begin
            clearInputs();
            adv = 1'b1;
            applyStimulus(0, 1, 11 + 2*g, 3, 0, 0);
            applyStimulus(1, 1, 12 + 2*g, 3, 0, 0);
            tick();
        end
        clearInputs();
        applyStimulus(0, 1, 0, 0, 17, 0);
        applyStimulus(1, 0, 0, 0, 0, 12);
        setData(3, 1, 32'hBEEF_0012);
        #1;
        checkOutput("full_s0_ready", 32'(ra1Ready[0]),  32'd0);
        checkOutput("full_s3_byp",   32'(ra2Bypass[1]), 32'd1);
        checkOutput("full_s3_data",  ra2Data[63:32],    32'hBEEF_0012);
        repeat (9) tick();
        checkOutput("full_stall", stallCnt, 32'd12);

        // Asynchronous reset mid-cycle clears everything before the next edge
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_stall",   stallCnt,          32'd0);
        checkOutput("arst_ready",   32'(ra1Ready[0]),  32'd1);
        checkOutput("arst_bypass0", 32'(ra1Bypass[0]), 32'd0);
        checkOutput("arst_bypass1", 32'(ra2Bypass[1]), 32'd0);
        checkOutput("arst_data1",   ra2Data[63:32],    32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
